// File: rtl/axi_ddr_rw_arbiter_if.sv
// axi_ddr_rw_arbiter_if: write/read request, completion and DDR command bundle around axi_ddr_rw_arbiter
interface axi_ddr_rw_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ID_W-1:0]   wr_id;
    logic              wr_done_valid;
    logic [ID_W-1:0]   wr_done_id;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [ID_W-1:0]   rd_id;
    logic              rd_rsp_valid;
    logic [DATA_W-1:0] rd_rsp_data;
    logic [ID_W-1:0]   rd_rsp_id;
    logic              ddr_cmd_valid;
    logic [ADDR_W-1:0] ddr_logical_addr;
    logic [DATA_W-1:0] ddr_pwdata;
    logic              ddr_pwrite;
    logic [DATA_W-1:0] ddr_prdata;

    modport slave (
        input  wr_req_valid, wr_addr, wr_data, wr_id,
        input  rd_req_valid, rd_addr, rd_id, ddr_prdata,
        output wr_req_ready, wr_done_valid, wr_done_id,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_id,
        output ddr_cmd_valid, ddr_logical_addr, ddr_pwdata, ddr_pwrite
    );

    modport master (
        output wr_req_valid, wr_addr, wr_data, wr_id,
        output rd_req_valid, rd_addr, rd_id, ddr_prdata,
        input  wr_req_ready, wr_done_valid, wr_done_id,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_id,
        input  ddr_cmd_valid, ddr_logical_addr, ddr_pwdata, ddr_pwrite
    );
endinterface

// File: rtl/axi_ddr_rw_arbiter.sv
// axi_ddr_rw_arbiter: shares the ddrcntrl command port between write and read paths, one op at a time
// Define ARB_STARVE_GUARD_EN for write priority with a forced read grant after MAX_GRANTS writes;
// otherwise both-valid requests alternate round robin.
module axi_ddr_rw_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int RD_LAT     = 2,
    parameter int MAX_GRANTS = 4
) (
    input logic                  aclk,
    input logic                  aresetn,
    axi_ddr_rw_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_ISSUE = 2'd1;
    localparam logic [1:0] RD_ISSUE = 2'd2;
    localparam logic [1:0] RD_WAIT  = 2'd3;

    if (RD_LAT < 1 || RD_LAT > 15 || MAX_GRANTS < 1) begin : g_param_check
        $error("axi_ddr_rw_arbiter: RD_LAT must be 1..15 and MAX_GRANTS at least 1");
    end

    logic [1:0]      state;
    logic            last_rd;
    logic [3:0]      wait_cnt;
    logic [ID_W-1:0] op_id;
    logic            idle;
    logic            pick_rd;
    logic            grant_wr;
    logic            grant_rd;

`ifdef ARB_STARVE_GUARD_EN
    localparam int GC_W = $clog2(MAX_GRANTS + 1);
    logic [GC_W-1:0] grant_cnt;

    assign pick_rd = grant_cnt == GC_W'(MAX_GRANTS);

    // count write grants that bypassed a waiting read; any read grant clears it
    always_ff @(posedge aclk) begin
        if (aresetn)
            grant_cnt <= '0;
        else if (grant_rd)
            grant_cnt <= '0;
        else if (grant_wr && bus.rd_req_valid && grant_cnt != GC_W'(MAX_GRANTS))
            grant_cnt <= grant_cnt + 1'b1;
    end
`else
    assign pick_rd = !last_rd;
`endif

    assign idle             = state == IDLE && !aresetn;
    assign grant_wr         = idle && bus.wr_req_valid && (!bus.rd_req_valid || !pick_rd);
    assign grant_rd         = idle && bus.rd_req_valid && (!bus.wr_req_valid || pick_rd);
    assign bus.wr_req_ready = grant_wr;
    assign bus.rd_req_ready = grant_rd;

    // request FSM: accept in IDLE, strobe the DDR command, then pulse the completion
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state                <= IDLE;
            last_rd              <= 1'b1;
            wait_cnt             <= '0;
            op_id                <= '0;
            bus.ddr_cmd_valid    <= 1'b0;
            bus.ddr_logical_addr <= '0;
            bus.ddr_pwdata       <= '0;
            bus.ddr_pwrite       <= 1'b0;
            bus.wr_done_valid    <= 1'b0;
            bus.wr_done_id       <= '0;
            bus.rd_rsp_valid     <= 1'b0;
            bus.rd_rsp_data      <= '0;
            bus.rd_rsp_id        <= '0;
        end else begin
            bus.ddr_cmd_valid <= 1'b0;
            bus.wr_done_valid <= 1'b0;
            bus.rd_rsp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state                <= WR_ISSUE;
                        last_rd              <= 1'b0;
                        op_id                <= bus.wr_id;
                        bus.ddr_cmd_valid    <= 1'b1;
                        bus.ddr_pwrite       <= 1'b1;
                        bus.ddr_logical_addr <= bus.wr_addr;
                        bus.ddr_pwdata       <= bus.wr_data;
                    end else if (grant_rd) begin
                        state                <= RD_ISSUE;
                        last_rd              <= 1'b1;
                        op_id                <= bus.rd_id;
                        bus.ddr_cmd_valid    <= 1'b1;
                        bus.ddr_pwrite       <= 1'b0;
                        bus.ddr_logical_addr <= bus.rd_addr;
                        bus.ddr_pwdata       <= '0;
                    end
                end
                WR_ISSUE: begin
                    state             <= IDLE;
                    bus.wr_done_valid <= 1'b1;
                    bus.wr_done_id    <= op_id;
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= 4'd1;
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'(RD_LAT)) begin
                        state            <= IDLE;
                        wait_cnt         <= '0;
                        bus.rd_rsp_valid <= 1'b1;
                        bus.rd_rsp_data  <= bus.ddr_prdata;
                        bus.rd_rsp_id    <= op_id;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ddr_rw_arbiter.sv
// tb_axi_ddr_rw_arbiter: scoreboard bench with a cycle-level arbitration/memory reference model
module tb_axi_ddr_rw_arbiter;
    localparam int AW = 32, DW = 32, IW = 4, RD_LAT = 2, MAXG = 4;

    typedef struct {int due; logic [AW-1:0] addr; logic [DW-1:0] data; logic wr;} cmd_t;
    typedef struct {int due; logic [IW-1:0] id; logic [DW-1:0] data;} rsp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    axi_ddr_rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus();

    axi_ddr_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RD_LAT(RD_LAT), .MAX_GRANTS(MAXG)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    cmd_t cmd_q[$];
    rsp_t wdone_q[$];
    rsp_t rrsp_q[$];
    logic cmd_log[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [DW-1:0] ddr_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // DDR controller stand-in: stores writes, returns read data exactly RD_LAT cycles after the command
    initial begin
        int pend = 0;
        logic drive;
        logic [DW-1:0] pd = '0;
        bus.ddr_prdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            drive = 1'b0;
            if (pend > 0) begin
                pend--;
                drive = pend == 0;
            end
            bus.ddr_prdata = drive ? pd : DW'($urandom);
            if (bus.ddr_cmd_valid === 1'b1) begin
                if (bus.ddr_pwrite) ddr_mem[bus.ddr_logical_addr] = bus.ddr_pwdata;
                else begin
                    pend = RD_LAT;
                    pd = ddr_mem.exists(bus.ddr_logical_addr) ? ddr_mem[bus.ddr_logical_addr] : init_val(bus.ddr_logical_addr);
                end
            end
        end
    end

    // reference model and monitor
    int m_free = 0;
    logic m_last_rd = 1'b1;
    int m_gcnt = 0;
    logic prev_rst = 1'b0;
    logic started = 1'b0;
    logic [DW-1:0] exp_rsp_data = '0;
    logic exp_wr, exp_rd, pick_rd;
    cmd_t c;
    rsp_t r;

    always @(negedge aclk) begin
        if (bus.ddr_cmd_valid === 1'b1) begin
            cmd_log.push_back(bus.ddr_pwrite);
            if (cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ddr_cmd_unexpected: strobe at cycle %0d, none required", cyc);
            end else begin
                c = cmd_q.pop_front();
                chk("ddr_cmd_cycle", cyc, c.due);
                chk("ddr_logical_addr", bus.ddr_logical_addr, c.addr);
                chk("ddr_pwdata", bus.ddr_pwdata, c.data);
                chk("ddr_pwrite", bus.ddr_pwrite, c.wr);
            end
        end
        while (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
            chk("ddr_cmd_missing", cyc, cmd_q[0].due);
            void'(cmd_q.pop_front());
        end
        if (bus.wr_done_valid === 1'b1) begin
            if (wdone_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_done_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                r = wdone_q.pop_front();
                chk("wr_done_cycle", cyc, r.due);
                chk("wr_done_id", bus.wr_done_id, r.id);
            end
        end
        while (wdone_q.size() > 0 && wdone_q[0].due < cyc) begin
            chk("wr_done_missing", cyc, wdone_q[0].due);
            void'(wdone_q.pop_front());
        end
        if (bus.rd_rsp_valid === 1'b1) begin
            if (rrsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_rsp_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                r = rrsp_q.pop_front();
                exp_rsp_data = r.data;
                chk("rd_rsp_cycle", cyc, r.due);
                chk("rd_rsp_id", bus.rd_rsp_id, r.id);
            end
        end
        while (rrsp_q.size() > 0 && rrsp_q[0].due < cyc) begin
            chk("rd_rsp_missing", cyc, rrsp_q[0].due);
            void'(rrsp_q.pop_front());
        end
        if (started) chk("rd_rsp_data", bus.rd_rsp_data, exp_rsp_data);
        if (prev_rst) begin
            chk("reset_ddr_outputs", {bus.ddr_cmd_valid, bus.ddr_logical_addr, bus.ddr_pwdata, bus.ddr_pwrite}, '0);
            chk("reset_rsp_outputs", {bus.wr_done_valid, bus.wr_done_id, bus.rd_rsp_valid, bus.rd_rsp_data, bus.rd_rsp_id}, '0);
        end
        exp_wr = 1'b0;
        exp_rd = 1'b0;
        if (!aresetn && started && cyc >= m_free) begin
`ifdef ARB_STARVE_GUARD_EN
            pick_rd = m_gcnt >= MAXG;
`else
            pick_rd = !m_last_rd;
`endif
            if (bus.wr_req_valid && bus.rd_req_valid) begin
                exp_rd = pick_rd;
                exp_wr = !pick_rd;
            end else begin
                exp_wr = bus.wr_req_valid;
                exp_rd = bus.rd_req_valid;
            end
        end
        chk("wr_req_ready", bus.wr_req_ready, exp_wr);
        chk("rd_req_ready", bus.rd_req_ready, exp_rd);
        if (exp_wr) begin
            cmd_q.push_back('{cyc + 1, bus.wr_addr, bus.wr_data, 1'b1});
            wdone_q.push_back('{cyc + 2, bus.wr_id, '0});
            mem_model[bus.wr_addr] = bus.wr_data;
            m_free = cyc + 2;
            m_last_rd = 1'b0;
            if (bus.rd_req_valid && m_gcnt < MAXG) m_gcnt++;
        end else if (exp_rd) begin
            cmd_q.push_back('{cyc + 1, bus.rd_addr, '0, 1'b0});
            rrsp_q.push_back('{cyc + 2 + RD_LAT, bus.rd_id,
                mem_model.exists(bus.rd_addr) ? mem_model[bus.rd_addr] : init_val(bus.rd_addr)});
            m_free = cyc + 2 + RD_LAT;
            m_last_rd = 1'b1;
            m_gcnt = 0;
        end
        if (aresetn) begin
            cmd_q.delete();
            wdone_q.delete();
            rrsp_q.delete();
            m_free = cyc + 1;
            m_last_rd = 1'b1;
            m_gcnt = 0;
            exp_rsp_data = '0;
            started = 1'b1;
        end
        prev_rst = aresetn;
    end

    task automatic wr_send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] id);
        int n = 0;
        bus.wr_req_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_id = id;
        @(negedge aclk);
        while (!bus.wr_req_ready && n < 300) begin @(negedge aclk); n++; end
        if (!bus.wr_req_ready) begin
            checks++; errors++;
            $display("FAIL wr_accept_timeout: no ready after %0d cycles, required within 300", n);
        end
        @(posedge aclk); #1;
        bus.wr_req_valid = 1'b0;
    endtask

    task automatic rd_send(input logic [AW-1:0] a, input logic [IW-1:0] id);
        int n = 0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = a; bus.rd_id = id;
        @(negedge aclk);
        while (!bus.rd_req_ready && n < 300) begin @(negedge aclk); n++; end
        if (!bus.rd_req_ready) begin
            checks++; errors++;
            $display("FAIL rd_accept_timeout: no ready after %0d cycles, required within 300", n);
        end
        @(posedge aclk); #1;
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic check_order(input string name, input int base, input string pat);
        chk({name, "_count"}, cmd_log.size() - base, pat.len());
        if (cmd_log.size() - base >= pat.len())
            for (int i = 0; i < pat.len(); i++) chk(name, cmd_log[base + i], pat[i] == "W");
    endtask

    task automatic burst(input string name, input int nw, input int nr, input string pat);
        int base = cmd_log.size();
        fork
            for (int i = 0; i < nw; i++) wr_send(32'h200 + 32'(4 * i), $urandom, IW'(i));
            for (int j = 0; j < nr; j++) rd_send(32'h200 + 32'(4 * j), IW'(8 + j));
        join
        idle_cycles(RD_LAT + 4);
        check_order(name, base, pat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_req_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_id = '0;
        bus.rd_req_valid = 1'b0; bus.rd_addr = '0; bus.rd_id = '0;
        repeat (3) begin
            bus.wr_req_valid = 1'($urandom); bus.wr_addr = $urandom; bus.wr_data = $urandom; bus.wr_id = IW'($urandom);
            bus.rd_req_valid = 1'($urandom); bus.rd_addr = $urandom; bus.rd_id = IW'($urandom);
            @(posedge aclk); #1;
        end
        aresetn = 1'b0;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        idle_cycles(2);
        wr_send(32'h40, 32'hDEAD_BEEF, 4'd3);
        idle_cycles(3);
        rd_send(32'h40, 4'd5);
        idle_cycles(RD_LAT + 3);
`ifdef ARB_STARVE_GUARD_EN
        burst("order_both_valid", 4, 4, "WWWWRRRR");
        burst("order_starve_guard", 8, 2, "WWWWRWWWWR");
`else
        burst("order_both_valid", 4, 4, "WRWRWRWR");
`endif
        rd_send(32'h80, 4'd7);
        idle_cycles(1);
        aresetn = 1'b1;
        idle_cycles(1);
        aresetn = 1'b0;
        idle_cycles(1);
        wr_send(32'h84, 32'h1234_5678, 4'd2);
        idle_cycles(3);
        rd_send(32'h84, 4'd6);
        idle_cycles(RD_LAT + 3);
        fork
            for (int i = 0; i < 30; i++) begin
                idle_cycles($urandom_range(0, 3));
                wr_send(32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, IW'($urandom));
            end
            for (int j = 0; j < 30; j++) begin
                idle_cycles($urandom_range(0, 3));
                rd_send(32'h100 + 32'(4 * $urandom_range(0, 7)), IW'($urandom));
            end
        join
        idle_cycles(RD_LAT + 10);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("wr_done_queue_drained", wdone_q.size(), 0);
        chk("rd_rsp_queue_drained", rrsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
